// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Frame results are 5 bits wide: bit 4 set encodes an empty frame (NO_KEY).
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef logic [3:0] key_code_t;
    typedef logic [4:0] frame_res_t;

    localparam frame_res_t NO_KEY = 5'b1_0000;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

    // Lowest active column of one row, or NO_KEY when the row is quiet.
    function automatic frame_res_t lowest_col(input logic [1:0] row, input logic [COLS-1:0] hit);
        frame_res_t res;
        res = NO_KEY;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (hit[c]) res = {1'b0, row, c[1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Slot divider, rotating active-low row drive, column synchroniser and
// per-frame lowest-code capture; frame_done marks the last clk of slot 3.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] cols,
    output logic [ROWS-1:0] rows,
    output logic            frame_done,
    output frame_res_t      frame_result
);

    if (SCAN_DIV_W < 2) begin : g_bad_div
        $error("SCAN_DIV_W must be at least 2");
    end

    logic [SCAN_DIV_W-1:0] div_cnt;
    logic [1:0]            row_idx;
    logic [COLS-1:0]       cols_meta;
    logic [COLS-1:0]       cols_sync;
    frame_res_t            best;
    frame_res_t            slot_res;
    frame_res_t            merged;
    logic                  slot_last;

    assign slot_last = &div_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            row_idx   <= 2'd0;
            cols_meta <= '1;
            cols_sync <= '1;
            best      <= NO_KEY;
        end else begin
            div_cnt   <= div_cnt + SCAN_DIV_W'(1);
            cols_meta <= cols;
            cols_sync <= cols_meta;
            if (slot_last) begin
                row_idx <= row_idx + 2'd1;
                best    <= (row_idx == 2'd3) ? NO_KEY : merged;
            end
        end
    end

    // Rows are scanned in ascending order, so the first hit of the frame is the lowest code.
    always_comb begin
        slot_res = lowest_col(row_idx, ~cols_sync);
        merged   = best[4] ? slot_res : best;
    end

    assign rows         = ~(ROWS'(1) << row_idx);
    assign frame_done   = slot_last && (row_idx == 2'd3);
    assign frame_result = merged;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: frame-level debounce FSM and four-digit shift register.
// Define KEYPAD_AUTOREPEAT_EN to re-accept a held key every REPEAT_FRAMES frames.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W      = 16,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] cols,
    output logic [ROWS-1:0] rows,
    output logic [15:0]     dout,
    output logic            key_valid,
    output key_code_t       key_code,
    output logic            key_down
);

    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_db
        $error("DEBOUNCE_FRAMES must be in 1..15");
    end
    if (REPEAT_FRAMES < 1) begin : g_bad_rep
        $error("REPEAT_FRAMES must be at least 1");
    end

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_FRAMES);

    logic       frame_done;
    frame_res_t frame_result;
    kp_state_t  state, state_nx;
    logic [3:0] cnt, cnt_nx;
    key_code_t  cand, cand_nx;
    logic       accept;
    logic       repeat_fire;
    logic       accept_any;
    logic       key_seen;

    keypad_row_scanner #(.SCAN_DIV_W(SCAN_DIV_W)) u_scan (
        .clk          (clk),
        .rst_n        (rst_n),
        .cols         (cols),
        .rows         (rows),
        .frame_done   (frame_done),
        .frame_result (frame_result)
    );

    assign key_seen = !frame_result[4];

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        accept   = 1'b0;
        if (frame_done) begin
            unique case (state)
                IDLE: if (key_seen) begin
                    cand_nx = frame_result[3:0];
                    cnt_nx  = 4'd1;
                    if (DB_LAST == 4'd1) begin
                        accept   = 1'b1;
                        state_nx = PRESSED;
                    end else begin
                        state_nx = DEBOUNCE;
                    end
                end
                DEBOUNCE: if (!key_seen) begin
                    state_nx = IDLE;
                end else begin
                    if (frame_result[3:0] == cand) begin
                        cnt_nx = cnt + 4'd1;
                    end else begin
                        cand_nx = frame_result[3:0];
                        cnt_nx  = 4'd1;
                    end
                    if (cnt_nx == DB_LAST) begin
                        accept   = 1'b1;
                        state_nx = PRESSED;
                    end
                end
                PRESSED: if (!key_seen) begin
                    cnt_nx   = 4'd1;
                    state_nx = (DB_LAST == 4'd1) ? IDLE : RELEASE;
                end
                RELEASE: if (key_seen) begin
                    state_nx = PRESSED;
                end else begin
                    cnt_nx = cnt + 4'd1;
                    if (cnt_nx == DB_LAST) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int                REP_W       = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST_M1 = REP_W'(REPEAT_FRAMES - 1);

    logic [REP_W-1:0] rep_cnt, rep_nx;

    // Only frames that find the accepted key while already in PRESSED count towards a repeat.
    always_comb begin
        rep_nx      = rep_cnt;
        repeat_fire = 1'b0;
        if (frame_done) begin
            if (state == PRESSED && key_seen && frame_result[3:0] == cand) begin
                if (rep_cnt == REP_LAST_M1) begin
                    repeat_fire = 1'b1;
                    rep_nx      = '0;
                end else begin
                    rep_nx = rep_cnt + REP_W'(1);
                end
            end else begin
                rep_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_cnt <= '0;
        else        rep_cnt <= rep_nx;
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign accept_any = accept | repeat_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cand      <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            dout      <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cand      <= cand_nx;
            key_valid <= accept_any;
            if (accept_any) begin
                key_code <= cand_nx;
                dout     <= {dout[11:0], cand_nx};
            end
        end
    end

    assign key_down = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives cols from rows,
// and a frame-level reference model predicts every output after each frame.
module tb_keypad_scanner;

    localparam int SCAN_DIV_W      = 2;
    localparam int DEBOUNCE_FRAMES = 4;
    localparam int REPEAT_FRAMES   = 8;
    localparam int FRAME_CYC       = 4 << SCAN_DIV_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [15:0] dout;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [15:0] key_mask = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    keypad_scanner #(
        .SCAN_DIV_W      (SCAN_DIV_W),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cols      (cols),
        .rows      (rows),
        .dout      (dout),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Pressed switch at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[4*r+c] && !rows[r]) cols[c] = 1'b0;
    end

    always @(posedge clk) if (key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

    // ---------------- reference model ----------------
    int          hist[$];
    bit          held;
    int          m_code;
    logic [15:0] m_dout;
    bit          m_valid;
    int          m_accepts = 0;
    int          rep_run;
    int          prev_r;

    function automatic int lowest(input logic [15:0] mask);
        for (int i = 0; i < 16; i++) if (mask[i]) return i;
        return -1;
    endfunction

    function automatic bit last_all(input int v);
        if (hist.size() < DEBOUNCE_FRAMES) return 1'b0;
        for (int i = hist.size() - DEBOUNCE_FRAMES; i < hist.size(); i++)
            if (hist[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        held = 0; m_code = 0; m_dout = '0; m_valid = 0; rep_run = 0; prev_r = -1;
    endtask

    task automatic model_accept(input int code);
        logic [3:0] c4;
        c4 = 4'(code);
        m_valid = 1; m_code = code; m_dout = {m_dout[11:0], c4};
        held = 1; rep_run = 0; m_accepts++;
    endtask

    task automatic model_frame(input logic [15:0] mask);
        int r;
        r = lowest(mask);
        hist.push_back(r);
        m_valid = 0;
        if (!held) begin
            if (r >= 0 && last_all(r)) model_accept(r);
        end else if (last_all(-1)) begin
            held = 0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (r == m_code && prev_r >= 0) begin
                rep_run++;
                if (rep_run == REPEAT_FRAMES) model_accept(r);
            end else begin
                rep_run = 0;
            end
`endif
        end
        prev_r = r;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge in cycle 0 of a frame; returns at cycle 0 of the next frame.
    task automatic apply_frame(input logic [15:0] mask);
        key_mask = mask;
        repeat (FRAME_CYC) @(posedge clk);
        @(negedge clk);
        model_frame(mask);
    endtask

    task automatic frame_step(input string tag, input logic [15:0] mask);
        apply_frame(mask);
        check({tag, ".key_valid"}, 32'(key_valid), 32'(m_valid));
        check({tag, ".key_code"},  32'(key_code),  32'(m_code));
        check({tag, ".dout"},      32'(dout),      32'(m_dout));
        check({tag, ".key_down"},  32'(key_down),  32'(held));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rows"},      32'(rows),      32'h0000_000E);
        check({tag, ".dout"},      32'(dout),      32'h0);
        check({tag, ".key_valid"}, 32'(key_valid), 32'h0);
        check({tag, ".key_code"},  32'(key_code),  32'h0);
        check({tag, ".key_down"},  32'(key_down),  32'h0);
    endtask

    typedef struct {
        logic [15:0] mask;
        logic        valid;
        logic [3:0]  code;
        logic [15:0] dout;
        logic        down;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int p0;
        int digits[4];
        logic [15:0] pair;
        logic [15:0] m;

        // Single press of r1c2 (code 6) for 6 frames, then 5 released frames.
        for (int i = 0; i < 11; i++) begin
            tbl[i].mask  = (i < 6) ? 16'h0040 : 16'h0000;
            tbl[i].valid = (i == 3);
            tbl[i].code  = (i >= 3) ? 4'h6 : 4'h0;
            tbl[i].dout  = (i >= 3) ? 16'h0006 : 16'h0000;
            tbl[i].down  = (i >= 3 && i <= 8);
        end

        model_reset();
        @(negedge clk);
        #1 check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        p0 = pulse_cnt;
        for (int i = 0; i < 11; i++) begin
            apply_frame(tbl[i].mask);
            check($sformatf("single[%0d].key_valid", i), 32'(key_valid), 32'(tbl[i].valid));
            check($sformatf("single[%0d].key_code", i),  32'(key_code),  32'(tbl[i].code));
            check($sformatf("single[%0d].dout", i),      32'(dout),      32'(tbl[i].dout));
            check($sformatf("single[%0d].key_down", i),  32'(key_down),  32'(tbl[i].down));
        end
        check("single.pulses", 32'(pulse_cnt - p0), 32'd1);

        // Digit sequence 1, 9, A, C then a fifth key 3.
        digits = '{1, 9, 10, 12};
        for (int d = 0; d < 4; d++) begin
            m = 16'(1) << digits[d];
            repeat (6) frame_step("digits", m);
            repeat (6) frame_step("digits", 16'h0);
        end
        check("digits.dout4", 32'(dout), 32'h19AC);
        repeat (6) frame_step("digits", 16'h0008);
        repeat (6) frame_step("digits", 16'h0);
        check("digits.dout5", 32'(dout), 32'h9AC3);

        // Bounce on key 5: 2 present, 1 absent, 2 present, then absent.
        p0 = pulse_cnt;
        m  = 16'h0020;
        frame_step("bounce", m); frame_step("bounce", m);
        frame_step("bounce", 16'h0);
        frame_step("bounce", m); frame_step("bounce", m);
        frame_step("bounce", 16'h0);
        check("bounce.pulses", 32'(pulse_cnt - p0), 32'd0);
        check("bounce.key_down", 32'(key_down), 32'd0);
        repeat (3) frame_step("bounce.fresh", m);
        check("bounce.no_early_pulse", 32'(pulse_cnt - p0), 32'd0);
        frame_step("bounce.fresh", m);
        check("bounce.accept", 32'(key_valid), 32'd1);
        repeat (4) frame_step("bounce.rel", 16'h0);

        // Keys 3 and D together, then a release bounce.
        p0   = pulse_cnt;
        pair = 16'h2008;
        repeat (6) frame_step("multi", pair);
        check("multi.key_code", 32'(key_code), 32'h3);
        frame_step("multi.relbounce", 16'h0);
        repeat (2) frame_step("multi.relbounce", pair);
        repeat (5) frame_step("multi.rel", 16'h0);
        check("multi.pulses", 32'(pulse_cnt - p0), 32'd1);
        check("multi.key_down", 32'(key_down), 32'd0);

        // Hold key 7 for 40 frames after acceptance.
        p0 = pulse_cnt;
        repeat (DEBOUNCE_FRAMES + 40) frame_step("hold", 16'h0080);
        repeat (5) frame_step("hold.rel", 16'h0);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("hold.pulses", 32'(pulse_cnt - p0), 32'd6);
        check("hold.dout", 32'(dout), 32'h7777);
`else
        check("hold.pulses", 32'(pulse_cnt - p0), 32'd1);
        check("hold.dout", 32'(dout), 32'h3537);
`endif

        // Reset while debouncing key 5 (count 2), key still held afterwards.
        m = 16'h0020;
        repeat (2) frame_step("midrst", m);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_values("midrst.async");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        p0 = pulse_cnt;
        repeat (3) frame_step("midrst.fresh", m);
        check("midrst.no_early_pulse", 32'(pulse_cnt - p0), 32'd0);
        frame_step("midrst.fresh", m);
        check("midrst.accept", 32'(key_valid), 32'd1);
        check("midrst.dout", 32'(dout), 32'h0005);
        repeat (5) frame_step("midrst.rel", 16'h0);

        // Randomised runs of none, single or paired keys.
        for (int s = 0; s < 40; s++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       m = 16'h0;
                3:       m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                default: m = 16'(1) << $urandom_range(0, 15);
            endcase
            repeat ($urandom_range(1, 7)) frame_step("random", m);
        end
        repeat (5) frame_step("random.rel", 16'h0);
        check("total.pulses", 32'(pulse_cnt), 32'(m_accepts));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 hex keypad and assembles the accepted key codes into a 16-bit, four-digit value. Its `dout` feeds the seven-segment display driver's `din` directly, with the most recently entered digit in the rightmost position. Row drive uses the same active-low, rotating one-hot scheme as the display's digit grounds. Column inputs are synchronised, debounced across whole scan frames, and decoded into single-cycle key events.

## Interface
- `SCAN_DIV_W`, 16: a row slot lasts 2^SCAN_DIV_W clk cycles; minimum legal value 2.
- `DEBOUNCE_FRAMES`, 4: number of consecutive identical frames required to accept a press or a release; range 1..15.
- `REPEAT_FRAMES`, 32: auto-repeat period in frames; used only when `KEYPAD_AUTOREPEAT_EN` is defined.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cols`  in  4  keypad columns, active-low, externally pulled up, asynchronous.
- `rows`  out  4  row drive, active-low one-hot; reset value 4'b1110.
- `dout`  out  16  entered digits, newest in [3:0]; reset value 16'h0000.
- `key_valid`  out  1  one-cycle pulse per accepted key; reset value 0.
- `key_code`  out  4  code of the last accepted key; reset value 0.
- `key_down`  out  1  high while an accepted key is held; reset value 0.

## Operation
- **Key code:** `{row[1:0], col[1:0]}`, i.e. 4*r + c, where row r is driven by `rows[r]` and column c is read on `cols[c]`.
- **Column sampling:** `cols` passes through a 2-flop synchroniser. The synchronised value is sampled on the last clk of each slot.
- **Row rotation:** `rows` rotates left, 1110 → 1101 → 1011 → 0111 → 1110, at each slot boundary.
- **Frame:** 4 slots. The frame result is either NONE or the lowest code seen during the frame. With multiple keys, the first row scanned wins, then the lowest column within that row.
- **FSM states:**
  - `IDLE`
    - Result NONE: stay.
    - Result key k: cand←k, cnt←1, go to `DEBOUNCE`.
  - `DEBOUNCE`
    - Result equals cand: cnt++.
    - Result is a different key: cand←new, cnt←1.
    - Result NONE: go to `IDLE`.
    - When cnt reaches DEBOUNCE_FRAMES: accept, go to `PRESSED`.
  - `PRESSED`
    - Any key present: stay.
    - Result NONE: cnt←1, go to `RELEASE`.
  - `RELEASE`
    - Result NONE: cnt++.
    - Any key present: go back to `PRESSED`; no new event is generated.
    - When cnt reaches DEBOUNCE_FRAMES: go to `IDLE`.
- **Accept:** `key_valid`=1 for one cycle, `key_code`←cand, `dout`←{`dout`[11:0], cand}.
- `key_down` = 1 in `PRESSED` and `RELEASE`.
- `dout` wraps naturally: the fifth key shifts the oldest digit out.
- **Reset mid-operation:** all state and outputs return to their reset values immediately; no `key_valid` is generated.

## Timing
- Slot length is S = 2^SCAN_DIV_W clk cycles; frame length is 4S.
- Synchroniser latency is 2 cycles, which is less than S, so each sample reflects the currently driven row.
- The frame result is evaluated on the last clk of slot 3 (`rows`=0111).
- FSM updates occur on the cycle after the frame result is evaluated.
- `key_valid`, `key_code` and `dout` update in the same cycle.
- **Minimum latency from a stable press to `key_valid`:** DEBOUNCE_FRAMES frames plus 1 cycle, measured from the start of the first full frame in which the key is present.
- The first slot after reset begins on the cycle `rst_n` deasserts.

## Configuration
- **`KEYPAD_AUTOREPEAT_EN` defined:**
  - In `PRESSED`, a frame counter counts held frames and is cleared on acceptance.
  - Every REPEAT_FRAMES frames with the same key still present, a new accept event occurs (pulse plus shift).
  - A different key appearing while in `PRESSED` does not repeat.
- **`KEYPAD_AUTOREPEAT_EN` undefined:** exactly one accept per press; the repeat counter is not synthesised.

## Structure
- **`keypad_pkg`:**
  - `ROWS`/`COLS` = 4
  - `key_code_t` (logic [3:0])
  - `kp_state_t` enum {IDLE, DEBOUNCE, PRESSED, RELEASE}
  - `NO_KEY` sentinel encoding (5-bit frame result, bit 4 = none)
- **Sub-module `keypad_row_scanner`:** contains the slot divider, row rotation, synchroniser and per-frame lowest-code capture. It outputs `frame_done` (1 cycle) and `frame_result`. The top level holds the FSM, the counters and `dout`.

## Test plan
Bench parameters: SCAN_DIV_W=2 (16 clk per frame), DEBOUNCE_FRAMES=4.
- **Single press:** press r1c2 for 6 frames, then release → exactly one `key_valid`, `key_code`=6, `dout`=16'h0006, `key_down` falling 4 frames after release.
- **Digit sequence:** enter codes 1, 9, A, C, each held 6 frames with 6 released frames between → `dout`=16'h19AC. A fifth key 3 → 16'h9AC3.
- **Bounce:** key 5 present for 2 frames, absent 1, present 2 → no `key_valid`, FSM back in `IDLE`.
- **Multiple keys:** codes 3 and D held together for 6 frames → `key_code`=3. Release bounce (1 empty frame, then key present again) → no second pulse.
- **Auto-repeat:** hold key 7 for 40 frames after acceptance.
  - Macro undefined → 1 pulse.
  - Macro defined, REPEAT_FRAMES=8 → 6 pulses, `dout`=16'h7777.
- **Reset mid-operation:** assert `rst_n`=0 during `DEBOUNCE` (cnt=2) → `rows`=1110, `dout`=0, `key_valid`=0, `key_down`=0 asynchronously. After release, a fresh 4-frame debounce is needed before any pulse.
